axi_wr_rsp_gen: RTL
===================

AXI_WR_RSP_GEN -- requirements
Module: axi_wr_rsp_gen

Interface
REQ-001 SHALL have parameter ID_MAX_WIDTH, default 12, meaning B-channel ID width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning pending-response queue entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmpl_valid  input  1  write-completion notice valid from the slave datapath.
REQ-006 SHALL have port cmpl_ready  output  1  queue can accept a completion.
REQ-007 SHALL have port cmpl_id  input  ID_MAX_WIDTH  ID of the completed write.
REQ-008 SHALL have port cmpl_resp  input  2  response code (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).
REQ-009 SHALL have port cmpl_user  input  1  user sideband.
REQ-010 SHALL have port bvalid  output  1  B-channel valid.
REQ-011 SHALL have port bready  input  1  B-channel ready from the master.
REQ-012 SHALL have port bid  output  ID_MAX_WIDTH  B-channel ID.
REQ-013 SHALL have port bresp  output  2  B-channel response.
REQ-014 SHALL have port buser  output  1  B-channel user.
REQ-015 SHALL have port rsp_cnt  output  16  completed B handshakes, wrapping.
REQ-016 SHALL have port err_cnt  output  16  completed B handshakes with bresp[1]=1, saturating.
REQ-017 SHALL have port pending  output  $clog2(DEPTH)+1  queued entries plus the entry held on B.

Function
REQ-018 SHALL accept a completion when cmpl_valid && cmpl_ready at a clock edge.
REQ-019 SHALL drive cmpl_ready = (pending < DEPTH+1) as a registered-state function, with no combinational path from bready.
REQ-020 SHALL store accepted completions in FIFO order; responses SHALL leave on B in acceptance order, with no reordering by ID.
REQ-021 SHALL hold the B payload in an output register separate from the DEPTH-entry queue; total capacity is DEPTH+1.
REQ-022 SHALL, when the output register is empty or handshaking this cycle and the queue is empty, load an accepted completion directly into the output register; bvalid rises one cycle after acceptance.
REQ-023 SHALL, when the output register is empty or handshaking this cycle and the queue is non-empty, load the queue head into the output register; queue push and pop in the same cycle are permitted.
REQ-024 SHALL keep bvalid asserted and bid/bresp/buser stable from assertion until the cycle of bvalid && bready.
REQ-025 SHALL never deassert bvalid without a handshake, except on rst.
REQ-026 SHALL sustain one response per cycle when bready is held high and completions arrive every cycle.
REQ-027 SHALL update pending each cycle as pending + accept - handshake.
REQ-028 SHALL increment rsp_cnt by 1 per handshake, wrapping from 0xFFFF to 0x0000.
REQ-029 SHALL increment err_cnt by 1 per handshake with bresp in {10, 11}, holding at 0xFFFF.
REQ-030 SHALL produce no B output for cmpl_valid while cmpl_ready=0; that completion is not accepted, and the source holds it.
REQ-031 SHALL leave queue state uncorrupted on X-free bready toggling while bvalid=0.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set the following by the next cycle: bvalid=0, bid=0, bresp=00, buser=0, rsp_cnt=0, err_cnt=0, pending=0, cmpl_ready=1, and empty queue pointers.
REQ-033 SHALL discard all queued and in-flight responses on rst asserted mid-operation; rst SHALL override a simultaneous accept or handshake.
REQ-034 SHALL hold cmpl_ready=1 and bvalid=0 throughout rst assertion, and ignore cmpl_valid while rst=1.

Verification
REQ-035 Single OKAY: completion id=0x5A, resp=00 accepted at cycle N, bready=1 -> bvalid=1, bid=0x5A, bresp=00 at N+1; bvalid=0 at N+2; rsp_cnt=1.
REQ-036 Backpressure/full: bready=0, 6 completions offered with DEPTH=4 -> 5 accepted, cmpl_ready=0 after the 5th, pending=5; bid stable at the first ID; releasing bready drains all 5 in order, 1 per cycle.
REQ-037 Streaming: completions every cycle with bready=1 for 100 cycles -> 100 handshakes, no bubbles after the first, pending <= 1, rsp_cnt=100.
REQ-038 Errors: responses 00, 10, 11, 01 -> err_cnt=2, rsp_cnt=4; err_cnt preset near 0xFFFF saturates at 0xFFFF; rsp_cnt wraps 0xFFFF to 0.
REQ-039 Reset mid-stream: 3 entries pending, bvalid=1, rst=1 for 1 cycle -> next cycle bvalid=0, pending=0, counters 0, cmpl_ready=1; a subsequent completion appears on B after 1 cycle.
REQ-040 Bready toggling: random bready with random completions -> scoreboard shows ID/resp/user order preserved, and payload stable while bvalid && !bready.

Source files
------------

// File: rtl/axi_wr_rsp_gen.sv
// AXI B-channel response generator: write completions are queued in FIFO order and
// presented on B through a dedicated output register, so capacity is DEPTH+1.
module axi_wr_rsp_gen #(
    parameter int ID_MAX_WIDTH = 12,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmpl_valid,
    output logic                     cmpl_ready,
    input  logic [ID_MAX_WIDTH-1:0]  cmpl_id,
    input  logic [1:0]               cmpl_resp,
    input  logic                     cmpl_user,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [ID_MAX_WIDTH-1:0]  bid,
    output logic [1:0]               bresp,
    output logic                     buser,
    output logic [15:0]              rsp_cnt,
    output logic [15:0]              err_cnt,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = ID_MAX_WIDTH + 3;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [EW-1:0]            mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            cnt_q, cnt_d;
    logic                     bvalid_q, bvalid_d;
    logic [EW-1:0]            bpay_q, bpay_d;
    logic [15:0]              rsp_cnt_q, rsp_cnt_d;
    logic [15:0]              err_cnt_q, err_cnt_d;

    logic                     hs, out_free, q_empty, accept, pop, load_direct, push;
    logic [EW-1:0]            cmpl_pay;
    logic [PW-1:0]            pending_w;

    // Pending and ready derive only from registered state, never from bready.
    assign pending_w  = cnt_q + {{AW{1'b0}}, bvalid_q};
    assign cmpl_ready = (pending_w <= DEPTH_P);
    assign cmpl_pay   = {cmpl_user, cmpl_resp, cmpl_id};

    always_comb begin
        hs          = bvalid_q & bready;
        out_free    = ~bvalid_q | hs;
        q_empty     = (cnt_q == '0);
        accept      = cmpl_valid & cmpl_ready;
        pop         = out_free & ~q_empty;
        load_direct = out_free & q_empty & accept;
        push        = accept & ~load_direct;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        bvalid_d = bvalid_q;
        bpay_d   = bpay_q;
        if (out_free) begin
            bvalid_d = pop | load_direct;
            if (pop) begin
                bpay_d = mem_q[rd_ptr_q];
            end else if (load_direct) begin
                bpay_d = cmpl_pay;
            end
        end

        rsp_cnt_d = hs ? rsp_cnt_q + 16'd1 : rsp_cnt_q;
        err_cnt_d = err_cnt_q;
        if (hs && bpay_q[EW-2] && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            bvalid_q  <= 1'b0;
            bpay_q    <= '0;
            rsp_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            bvalid_q  <= bvalid_d;
            bpay_q    <= bpay_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Queue storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= cmpl_pay;
        end
    end

    assign bvalid  = bvalid_q;
    assign bid     = bpay_q[ID_MAX_WIDTH-1:0];
    assign bresp   = bpay_q[ID_MAX_WIDTH+1:ID_MAX_WIDTH];
    assign buser   = bpay_q[EW-1];
    assign rsp_cnt = rsp_cnt_q;
    assign err_cnt = err_cnt_q;
    assign pending = pending_w;

endmodule
